// File: rtl/hello_rxcheck.sv
// hello_rxcheck
// -------------
// UART receiver plus message checker: the receiving end of the board's
// "Hello, World! \n\r" transmit test. Deserialises frames from i_uart_rx,
// emits each byte with a one-cycle strobe, compares the byte stream against
// the fixed 16-character message and counts complete, correct messages.
//
// Parameters:
//   CLOCKS_PER_BAUD  clock cycles per bit (default 868 = 100 MHz / 115200),
//                    legal range 4 .. 2^24-1 (held in a 24-bit counter)
//
// Optional feature (compile-time macro RX_PARITY_EN):
//   undefined  8N1 frames, no parity state, no o_parity_err port
//   defined    8E1 frames, a PARITY state samples one even-parity bit between
//              the data bits and the stop bit; a bad parity bit with a good
//              stop bit raises o_parity_err instead of o_wr
//
// Ports:
//   i_clk         system clock
//   i_rst_n       asynchronous active-low reset
//   i_uart_rx     serial line, idle high, asynchronous to i_clk
//   o_wr          one-cycle strobe, o_data holds a freshly received byte
//   o_data        last received byte
//   o_frame_err   one-cycle strobe, stop bit sampled low
//   o_parity_err  one-cycle strobe, parity bit wrong (RX_PARITY_EN only)
//   o_msg_done    one-cycle strobe, full 16-character message matched
//   o_mismatch    one-cycle strobe, received byte differed from expectation
//   o_msg_count   number of complete messages matched, saturating
//
// Receiver FSM:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | line high, waiting for the falling edge of a start bit
//   START     | counting to mid start bit, re-checking it is still low
//   DATA      | sampling 8 data bits LSB-first at mid-bit
//   PARITY    | sampling the even-parity bit (RX_PARITY_EN only)
//   STOP      | sampling the stop bit, issuing o_wr or o_frame_err
//   WAIT_IDLE | stop bit was low (break); hold off until the line is high

module hello_rxcheck #(
    parameter int unsigned CLOCKS_PER_BAUD = 868
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_uart_rx,
    output logic        o_wr,
    output logic [7:0]  o_data,
    output logic        o_frame_err,
`ifdef RX_PARITY_EN
    output logic        o_parity_err,
`endif
    output logic        o_msg_done,
    output logic        o_mismatch,
    output logic [15:0] o_msg_count
);

    localparam logic [23:0] BAUD_FULL = 24'(CLOCKS_PER_BAUD - 1);
    // Half a bit period from the detected edge lands the START check (and
    // every later sample) in the middle of its bit.
    localparam logic [23:0] BAUD_HALF = 24'(CLOCKS_PER_BAUD / 2 - 1);

    localparam logic [3:0] LAST_IDX = 4'd15;
    localparam logic [7:0] CHAR_H   = 8'h48;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } rx_state_t;

    rx_state_t   state;
    logic [23:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        rx_meta;
    logic        rx_s;
    logic [3:0]  msg_idx;
`ifdef RX_PARITY_EN
    logic        par_bit;
`endif

    // Expected message "Hello, World! \n\r", indexed by match position.
    function automatic logic [7:0] exp_char(input logic [3:0] idx);
        logic [7:0] c;
        case (idx)
            4'd0:    c = 8'h48; // H
            4'd1:    c = 8'h65; // e
            4'd2:    c = 8'h6C; // l
            4'd3:    c = 8'h6C; // l
            4'd4:    c = 8'h6F; // o
            4'd5:    c = 8'h2C; // ,
            4'd6:    c = 8'h20; // space
            4'd7:    c = 8'h57; // W
            4'd8:    c = 8'h6F; // o
            4'd9:    c = 8'h72; // r
            4'd10:   c = 8'h6C; // l
            4'd11:   c = 8'h64; // d
            4'd12:   c = 8'h21; // !
            4'd13:   c = 8'h20; // space
            4'd14:   c = 8'h0A; // \n
            default: c = 8'h0D; // \r
        endcase
        return c;
    endfunction

    // Two-flop synchroniser; reset to the idle (high) line level so a reset
    // release never looks like a start bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // Receiver FSM with registered strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            o_wr         <= 1'b0;
            o_data       <= '0;
            o_frame_err  <= 1'b0;
`ifdef RX_PARITY_EN
            par_bit      <= 1'b0;
            o_parity_err <= 1'b0;
`endif
        end else begin
            o_wr         <= 1'b0;
            o_frame_err  <= 1'b0;
`ifdef RX_PARITY_EN
            o_parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        baud_cnt <= BAUD_HALF;
                    end
                end

                START: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - 24'd1;
                    end else if (rx_s) begin
                        // Line went high again before mid start bit: glitch.
                        state <= IDLE;
                    end else begin
                        state    <= DATA;
                        baud_cnt <= BAUD_FULL;
                        bit_cnt  <= 3'd0;
                    end
                end

                DATA: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - 24'd1;
                    end else begin
                        shreg    <= {rx_s, shreg[7:1]};
                        baud_cnt <= BAUD_FULL;
                        if (bit_cnt == 3'd7) begin
`ifdef RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end

`ifdef RX_PARITY_EN
                PARITY: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - 24'd1;
                    end else begin
                        par_bit  <= rx_s;
                        baud_cnt <= BAUD_FULL;
                        state    <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - 24'd1;
                    end else if (rx_s) begin
                        state <= IDLE;
`ifdef RX_PARITY_EN
                        // Even parity: data bits plus parity bit XOR to 0.
                        if (^{shreg, par_bit}) begin
                            o_parity_err <= 1'b1;
                        end else begin
                            o_wr   <= 1'b1;
                            o_data <= shreg;
                        end
`else
                        o_wr   <= 1'b1;
                        o_data <= shreg;
`endif
                    end else begin
                        // Framing error: o_data deliberately keeps the last
                        // good byte.
                        o_frame_err <= 1'b1;
                        state       <= WAIT_IDLE;
                    end
                end

                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Message checker, one cycle behind the receiver strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            msg_idx     <= '0;
            o_msg_done  <= 1'b0;
            o_mismatch  <= 1'b0;
            o_msg_count <= '0;
        end else begin
            o_msg_done <= 1'b0;
            o_mismatch <= 1'b0;
            if (o_wr) begin
                if (o_data == exp_char(msg_idx)) begin
                    if (msg_idx == LAST_IDX) begin
                        msg_idx    <= '0;
                        o_msg_done <= 1'b1;
                        if (o_msg_count != 16'hFFFF) begin
                            o_msg_count <= o_msg_count + 16'd1;
                        end
                    end else begin
                        msg_idx <= msg_idx + 4'd1;
                    end
                end else begin
                    o_mismatch <= 1'b1;
                    // A stray 'H' is taken as the start of a fresh message.
                    msg_idx    <= (o_data == CHAR_H) ? 4'd1 : 4'd0;
                end
            end else if (o_frame_err) begin
                msg_idx <= '0;
            end
`ifdef RX_PARITY_EN
            else if (o_parity_err) begin
                msg_idx <= '0;
            end
`endif
        end
    end

endmodule
